// File: rtl/whack_judge.sv
// Whack-a-mole judge: debounces player switches, clears whacked moles and
// reports per-round hit/miss/wrong counts over a valid/ready handshake.
module whack_judge #(
    parameter int N_HOLES  = 8,
    parameter int DB_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               tick,
    input  logic [N_HOLES-1:0] mole,
    input  logic [N_HOLES-1:0] sw,
    input  logic               sample_en,
    output logic [N_HOLES-1:0] led,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_hits,
    output logic [3:0]         res_miss,
    output logic [3:0]         res_wrong,
    output logic               overrun
);

    localparam logic [3:0] DB_MAX = 4'(DB_COUNT - 1);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    function automatic logic [3:0] popcount(input logic [N_HOLES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_HOLES; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    logic [N_HOLES-1:0] sync1_q, sync2_q, stable_q, toggle_q;
    logic [3:0]         db_cnt_q [N_HOLES];

    state_e             state_q, state_d;
    logic [N_HOLES-1:0] led_q, led_d;
    logic [3:0]         hits_acc_q, hits_acc_d;
    logic [3:0]         wrong_acc_q, wrong_acc_d;

    logic               rec_new;
    logic [3:0]         rec_hits, rec_miss, rec_wrong;

    logic [N_HOLES-1:0] led_after;
    logic [3:0]         hits_after, wrong_after;
    logic [4:0]         wrong_sum;

    logic               res_valid_q, overrun_q;
    logic [3:0]         res_hits_q, res_miss_q, res_wrong_q;

    // Synchronise and debounce switches; toggle_q pulses one clk after the accepting sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            toggle_q <= '0;
            for (int i = 0; i < N_HOLES; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= sw;
            sync2_q  <= sync1_q;
            toggle_q <= '0;
            if (sample_en) begin
                for (int i = 0; i < N_HOLES; i++) begin
                    if (sync2_q[i] != stable_q[i]) begin
                        if (db_cnt_q[i] == DB_MAX) begin
                            stable_q[i] <= ~stable_q[i];
                            db_cnt_q[i] <= '0;
                            toggle_q[i] <= 1'b1;
                        end else begin
                            db_cnt_q[i] <= db_cnt_q[i] + 4'd1;
                        end
                    end else begin
                        db_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    // Effect of this clk's toggles on the current round, used both mid-round and at close.
    always_comb begin
        led_after  = led_q & ~toggle_q;
        hits_after = hits_acc_q + popcount(toggle_q & led_q);
        wrong_sum  = {1'b0, wrong_acc_q} + {1'b0, popcount(toggle_q & ~led_q)};
        wrong_after = (wrong_sum > 5'd15) ? 4'd15 : wrong_sum[3:0];
    end

    // Round FSM next-state: scoring, LED pattern and record formation.
    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        hits_acc_d  = hits_acc_q;
        wrong_acc_d = wrong_acc_q;
        rec_new     = 1'b0;
        rec_hits    = '0;
        rec_miss    = '0;
        rec_wrong   = '0;
        unique case (state_q)
            StIdle: begin
                led_d       = '0;
                hits_acc_d  = '0;
                wrong_acc_d = '0;
                if (tick && run) begin
                    state_d = StPlay;
                    led_d   = mole;
                end
            end
            StPlay: begin
                if (!run) begin
                    state_d     = StIdle;
                    led_d       = '0;
                    hits_acc_d  = '0;
                    wrong_acc_d = '0;
                end else begin
                    led_d       = led_after;
                    hits_acc_d  = hits_after;
                    wrong_acc_d = wrong_after;
                    if (tick) begin
                        rec_new     = 1'b1;
                        rec_hits    = hits_after;
                        rec_miss    = popcount(led_after);
                        rec_wrong   = wrong_after;
                        led_d       = mole;
                        hits_acc_d  = '0;
                        wrong_acc_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Round state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            led_q       <= '0;
            hits_acc_q  <= '0;
            wrong_acc_q <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            hits_acc_q  <= hits_acc_d;
            wrong_acc_q <= wrong_acc_d;
        end
    end

    // Result record holding register; a new record always wins over a stalled one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_hits_q  <= '0;
            res_miss_q  <= '0;
            res_wrong_q <= '0;
            overrun_q   <= 1'b0;
        end else if (rec_new) begin
            res_valid_q <= 1'b1;
            res_hits_q  <= rec_hits;
            res_miss_q  <= rec_miss;
            res_wrong_q <= rec_wrong;
            if (res_valid_q && !res_ready) overrun_q <= 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign led       = led_q;
    assign res_valid = res_valid_q;
    assign res_hits  = res_hits_q;
    assign res_miss  = res_miss_q;
    assign res_wrong = res_wrong_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_whack_judge.sv
// Directed bench for whack_judge: records are checked by a scoreboard monitor,
// LEDs and status flags by direct checks from the stimulus thread.
module tb_whack_judge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, tick, sample_en, res_ready;
    logic [7:0] mole, sw, led;
    logic       res_valid, overrun;
    logic [3:0] res_hits, res_miss, res_wrong;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected records packed as {hits, miss, wrong}.
    logic [11:0] exp_q[$];

    whack_judge #(.N_HOLES(8), .DB_COUNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .tick      (tick),
        .mole      (mole),
        .sw        (sw),
        .sample_en (sample_en),
        .led       (led),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hits  (res_hits),
        .res_miss  (res_miss),
        .res_wrong (res_wrong),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge is accepted at the next posedge.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL record_unexpected: got %0h, expected none",
                         {res_hits, res_miss, res_wrong});
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({res_hits, res_miss, res_wrong} !== e) begin
                    n_fail++;
                    $display("FAIL record: got %0h, expected %0h",
                             {res_hits, res_miss, res_wrong}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pulse(input logic with_tick, input logic [7:0] m);
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        tick      = with_tick;
        mole      = m;
        step();
        tick = 1'b0;
    endtask

    // Flip switches and debounce; optional tick lands in the same clk as the toggle.
    task automatic whack(input logic [7:0] bits, input logic tick_last, input logic [7:0] m);
        sw = sw ^ bits;
        repeat (3) step();
        for (int k = 0; k < 3; k++) sample_pulse(1'b0, 8'h00);
        sample_pulse(tick_last, m);
    endtask

    task automatic do_tick(input logic [7:0] m);
        tick = 1'b1;
        mole = m;
        step();
        tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; tick = 1'b0; sample_en = 1'b0;
        res_ready = 1'b1; mole = 8'h00; sw = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_led", {4'h0, led}, 12'h000);
        check("reset_valid", {11'h0, res_valid}, 12'h000);
        check("reset_overrun", {11'h0, overrun}, 12'h000);
        check("reset_fields", {res_hits, res_miss, res_wrong}, 12'h000);
        rst_n = 1'b1;

        // Initial switch positions debounce in IDLE and never score.
        repeat (3) step();
        for (int k = 0; k < 4; k++) sample_pulse(1'b0, 8'h00);
        check("idle_led", {4'h0, led}, 12'h000);
        run = 1'b1;
        do_tick(8'hA5);
        check("first_tick_led", {4'h0, led}, 12'h0A5);
        check("first_tick_novalid", {11'h0, res_valid}, 12'h000);
        check("first_tick_wrong", {8'h0, res_wrong}, 12'h000);
        step();

        // Two hits, then close: hits=2 miss=2 wrong=0.
        whack(8'h05, 1'b0, 8'h00);
        check("hit_led", {4'h0, led}, 12'h0A0);
        exp_q.push_back({4'd2, 4'd2, 4'd0});
        do_tick(8'h3C);
        check("round1_led", {4'h0, led}, 12'h03C);
        check("round1_valid", {11'h0, res_valid}, 12'h001);
        repeat (2) step();
        check("round1_consumed", {11'h0, res_valid}, 12'h000);

        // Glitch on sw[1] shorter than the debounce window, then a real toggle (wrong).
        sw = sw ^ 8'h02;
        repeat (3) step();
        for (int k = 0; k < 2; k++) sample_pulse(1'b0, 8'h00);
        sw = sw ^ 8'h02;
        repeat (3) step();
        for (int k = 0; k < 2; k++) sample_pulse(1'b0, 8'h00);
        check("glitch_led", {4'h0, led}, 12'h03C);
        whack(8'h02, 1'b0, 8'h00);
        check("wrong_led", {4'h0, led}, 12'h03C);
        exp_q.push_back({4'd0, 4'd4, 4'd1});
        do_tick(8'h01);
        check("round2_led", {4'h0, led}, 12'h001);
        repeat (2) step();

        // Toggle bit 0 in the same clk as the closing tick.
        exp_q.push_back({4'd1, 4'd0, 4'd0});
        whack(8'h01, 1'b1, 8'h80);
        check("same_clk_led", {4'h0, led}, 12'h080);
        repeat (2) step();

        // Stalled consumer across two ticks, then accept with a third.
        res_ready = 1'b0;
        exp_q.push_back({4'd0, 4'd1, 4'd0});
        do_tick(8'hFF);
        check("stall_valid", {11'h0, res_valid}, 12'h001);
        check("stall_no_overrun", {11'h0, overrun}, 12'h000);
        step();
        void'(exp_q.pop_back());
        exp_q.push_back({4'd0, 4'd8, 4'd0});
        do_tick(8'h0F);
        check("overrun_set", {11'h0, overrun}, 12'h001);
        check("overrun_held", {res_hits, res_miss, res_wrong}, {4'd0, 4'd8, 4'd0});
        step();
        check("overrun_stable", {res_hits, res_miss, res_wrong}, {4'd0, 4'd8, 4'd0});
        exp_q.push_back({4'd0, 4'd4, 4'd0});
        tick = 1'b1; mole = 8'h00; res_ready = 1'b1;
        step();
        tick = 1'b0;
        check("accept_new_valid", {11'h0, res_valid}, 12'h001);
        check("accept_new_overrun", {11'h0, overrun}, 12'h001);
        check("accept_new_fields", {res_hits, res_miss, res_wrong}, {4'd0, 4'd4, 4'd0});
        repeat (2) step();

        // Twenty wrong toggles saturate at 15.
        whack(8'hFF, 1'b0, 8'h00);
        whack(8'hFF, 1'b0, 8'h00);
        whack(8'h0F, 1'b0, 8'h00);
        exp_q.push_back({4'd0, 4'd0, 4'd15});
        do_tick(8'hC3);
        check("sat_round_led", {4'h0, led}, 12'h0C3);
        repeat (2) step();

        // Drop run mid-round: LEDs dark, no record, fresh round afterwards.
        whack(8'h01, 1'b0, 8'h00);
        check("pre_drop_led", {4'h0, led}, 12'h0C2);
        run = 1'b0;
        step();
        check("drop_led", {4'h0, led}, 12'h000);
        check("drop_novalid", {11'h0, res_valid}, 12'h000);
        do_tick(8'hFF);
        check("idle_tick_led", {4'h0, led}, 12'h000);
        check("idle_tick_novalid", {11'h0, res_valid}, 12'h000);
        run = 1'b1;
        do_tick(8'h18);
        check("restart_led", {4'h0, led}, 12'h018);
        check("restart_novalid", {11'h0, res_valid}, 12'h000);
        whack(8'h08, 1'b0, 8'h00);
        exp_q.push_back({4'd1, 4'd1, 4'd0});
        do_tick(8'h00);
        check("fresh_round_valid", {11'h0, res_valid}, 12'h001);
        repeat (4) step();
        check("queue_drained", 12'(exp_q.size()), 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/whack_judge.md
Name: whack_judge

Overview:
- Player-side counterpart to the mole generator: takes each pseudo-random mole pattern from the game clock and judges the player's switch toggles against it.
- Synchronises and debounces the 8 raw switches, and clears each mole when its hole is whacked.
- At every round boundary, emits one result record (hits, misses, wrong whacks) over a valid/ready handshake to the score counter.
- Drives the live mole LEDs, so a whacked mole goes dark immediately.

Parameters:
- N_HOLES, 8, number of holes (switch/LED pairs); counts sized for ≤15.
- DB_COUNT, 4, consecutive differing sample_en samples required to accept a switch change (1..15).

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  game enable; low forces IDLE.
- tick  input  1  one-clk pulse per game-clock period; marks a new round.
- mole  input  N_HOLES  new mole pattern; sampled only when tick=1.
- sw  input  N_HOLES  raw asynchronous switch levels.
- sample_en  input  1  one-clk debounce sampling pulse (~200 Hz).
- led  output  N_HOLES  moles still standing in the current round.
- res_valid  output  1  result record available.
- res_ready  input  1  consumer accepts the record.
- res_hits  output  4  moles whacked in the closed round.
- res_miss  output  4  moles left standing at round close.
- res_wrong  output  4  toggles on empty holes; saturates at 15.
- overrun  output  1  sticky; a record was overwritten before acceptance.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all of the following to 0:
  - led, res_valid, res_hits, res_miss, res_wrong, overrun;
  - the synchronisers, stable levels, debounce counters and accumulators.
  - The FSM goes to IDLE.
- Synchroniser:
  - 2-flop synchroniser per sw bit; sync level = 2nd flop.
- Debounce, per bit, evaluated only on sample_en:
  - If sync ≠ stable, cnt increments.
  - When cnt reaches DB_COUNT-1 on a differing sample: stable flips, cnt clears, and toggle[i] pulses for exactly one clk (the clk after that sample_en).
  - If sync = stable, cnt clears.
  - Both switch directions count as a whack.
- FSM states:
  - IDLE: stable levels track normally, but toggles are ignored; led=0; no records are emitted.
  - IDLE→PLAY on tick && run: led←mole; accumulators cleared; no record emitted for this first tick.
  - PLAY→IDLE when run=0 (takes effect next clk): led←0; accumulators cleared; no record emitted. A pending record stays valid until accepted.
  - After reset, the first toggles (from initial switch positions) therefore never score.
- PLAY, each clk:
  - Per bit i with toggle[i]=1 and led[i]=1: clear led[i] and add 1 to hits_acc.
  - Per bit with toggle[i]=1 and led[i]=0: wrong_acc+1, saturating at 15.
  - Multiple bits toggling in the same clk are all counted.
- Round close (tick=1 in PLAY):
  - Toggles in the same clk are applied to the closing round first.
  - Record is formed as: res_hits=hits_acc (after those toggles), res_miss=popcount(led after those toggles), res_wrong=wrong_acc.
  - Then led←mole, hits_acc←0, wrong_acc←0.
  - Record appears with res_valid=1 one clk after tick.
- Handshake:
  - A record is accepted when res_valid && res_ready at a posedge clk.
  - The record fields are held stable while res_valid=1 && !res_ready.
  - New record arriving while res_valid && !res_ready: the new record overwrites the held one, overrun←1 (sticky until reset), res_valid stays 1.
  - Accept and new record in the same clk: the old record is consumed, the new one is loaded, res_valid stays 1, overrun unchanged.
  - Accept with no new record: res_valid←0.
- Invariant: res_hits+res_miss = popcount(pattern loaded at the start of that round).
- mole=0 is a legal pattern: the round has no hits or misses, and every toggle counts as wrong.

Test Plan:
- Reset then the first tick in IDLE: sw starts 8'hFF (debounces to stable=FF while IDLE); tick with mole=8'hA5 → led=A5, no res_valid, wrong stays 0.
- In PLAY with led=A5: debounced toggles on bits 0 and 2 → led=A0. Next tick with mole=8'h3C → record hits=2, miss=2, wrong=0; led=3C.
- Bouncing sw[1] glitch shorter than DB_COUNT samples (DB_COUNT=4, 2 differing samples then revert) → no toggle, led and counters unchanged. Steady for 4 samples → exactly one toggle.
- Toggle bit 0 in the same clk as tick (led=01, mole=8'h80): record hits=1, miss=0; led=80.
- res_ready held 0 across two ticks → overrun=1, second record held. Raise res_ready together with a third tick → res_valid stays 1 with the third record, overrun stays 1.
- 20 toggles on empty holes in one round → res_wrong=15. Drop run mid-round → led=0 next clk, no record, and the next tick with run=1 starts a fresh round.
